// File: rtl/p3_pll_pkg.sv
// Shared state encoding for the p3 PLL sequencer.
package p3_pll_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StOff      = 3'd0,
        StPwrdn    = 3'd1,
        StWaitLock = 3'd2,
        StFilter   = 3'd3,
        StHold     = 3'd4,
        StRun      = 3'd5,
        StFault    = 3'd6
    } pll_state_e;

    // PLL is released from POWERDOWN in these states.
    function automatic logic pll_on(input pll_state_e s);
        return s inside {StWaitLock, StFilter, StHold, StRun};
    endfunction

endpackage

// File: rtl/p3_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module p3_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/p3_pll_ctrl.sv
// PLL power-up, lock qualification and core reset sequencer with bounded retries.
module p3_pll_ctrl
    import p3_pll_pkg::*;
#(
    parameter int unsigned PD_CYCLES    = 16,
    parameter int unsigned LOCK_FILTER  = 64,
    parameter int unsigned RST_HOLD     = 8,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               CLKA,
    input  logic               RESETN,
    input  logic               ENABLE,
    input  logic               PLL_LOCK,
    output logic               PLL_POWERDOWN,
    output logic               CORE_RESETN,
    output logic               READY,
    output logic               FAULT,
    output logic [2:0]         RETRY_CNT,
    output logic [STATE_W-1:0] STATE
);

    localparam logic [CNT_W-1:0] PD_LAST   = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRIES);
    localparam bit               FILT_ONE  = (LOCK_FILTER == 1);

    logic             lock_s;
    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] filt_q, filt_d;
    logic [CNT_W-1:0] to_q, to_d;
    logic [2:0]       retry_q, retry_d;
    logic             retry_ev;
    logic             pd_q, core_rstn_q, ready_q, fault_q;

    p3_sync2 u_lock_sync (
        .clk_i  (CLKA),
        .rst_ni (RESETN),
        .d_i    (PLL_LOCK),
        .q_o    (lock_s)
    );

    // Counters default to zero so that every state entry starts them cleared.
    always_comb begin
        state_d  = state_q;
        phase_d  = '0;
        filt_d   = '0;
        to_d     = '0;
        retry_d  = retry_q;
        retry_ev = 1'b0;
        case (state_q)
            StOff: if (ENABLE) state_d = StPwrdn;
            StPwrdn: begin
                if (phase_q == PD_LAST) state_d = StWaitLock;
                else                    phase_d = phase_q + CNT_W'(1);
            end
            StWaitLock: begin
                to_d = to_q + CNT_W'(1);
                if (lock_s) begin
                    if (FILT_ONE) begin
                        state_d = StHold;
                    end else begin
                        state_d = StFilter;
                        filt_d  = CNT_W'(1);
                    end
                end
                retry_ev = (to_q == TO_LAST) && !(lock_s && FILT_ONE);
            end
            StFilter: begin
                to_d = to_q + CNT_W'(1);
                if (!lock_s)                state_d = StWaitLock;
                else if (filt_q == FILT_LAST) state_d = StHold;
                else                        filt_d = filt_q + CNT_W'(1);
                // Filter completion beats a coincident timeout.
                retry_ev = (to_q == TO_LAST) && !(lock_s && filt_q == FILT_LAST);
            end
            StHold: begin
                if (!lock_s) begin
                    retry_ev = 1'b1;
                end else if (phase_q == HOLD_LAST) begin
                    state_d = StRun;
                    retry_d = '0;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            StRun:   if (!lock_s) retry_ev = 1'b1;
            StFault: state_d = StFault;
            default: state_d = StOff;
        endcase

        if (retry_ev) begin
            phase_d = '0;
            filt_d  = '0;
            to_d    = '0;
            if (retry_q == RETRY_MAX) begin
                state_d = StFault;
            end else begin
                retry_d = retry_q + 3'd1;
                state_d = StPwrdn;
            end
        end

        if (!ENABLE) begin
            state_d = StOff;
            phase_d = '0;
            filt_d  = '0;
            to_d    = '0;
            retry_d = '0;
        end
    end

    always_ff @(posedge CLKA or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= StOff;
            phase_q     <= '0;
            filt_q      <= '0;
            to_q        <= '0;
            retry_q     <= '0;
            pd_q        <= 1'b0;
            core_rstn_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            filt_q      <= filt_d;
            to_q        <= to_d;
            retry_q     <= retry_d;
            pd_q        <= pll_on(state_d);
            core_rstn_q <= (state_d == StRun);
            ready_q     <= (state_d == StRun);
            fault_q     <= (state_d == StFault);
        end
    end

    assign PLL_POWERDOWN = pd_q;
    assign CORE_RESETN   = core_rstn_q;
    assign READY         = ready_q;
    assign FAULT         = fault_q;
    assign RETRY_CNT     = retry_q;
    assign STATE         = state_q;

endmodule
